// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU control codes,
// arbiter state encoding and fixed bus geometry.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int N_REQ  = 2;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_ADD = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_SHL = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_SHR = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_SRA = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_NOT = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_AND = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_GTU = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two ALU requesters, the arbiter and the
// result consumer.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*CTRL_W-1:0] req_ctrl;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_zero;
    logic                    rsp_id;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_id, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: modulo-2^WIDTH arithmetic, logic, shifts and an
// unsigned compare, plus a zero flag on the result.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  result,
    output logic              zero
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic                    shift_big;
    logic signed [WIDTH-1:0] sra_val;

    // Shift amount is the whole of B; anything at or beyond WIDTH saturates.
    assign shift_big = |b[WIDTH-1:SHAMT_W];
    assign sra_val   = $signed(a) >>> b[SHAMT_W-1:0];

    always_comb begin
        result = a + b;
        case (ctrl)
            ALU_SUB: result = a - b;
            ALU_SHL: result = shift_big ? '0 : (a << b[SHAMT_W-1:0]);
            ALU_SHR: result = shift_big ? '0 : (a >> b[SHAMT_W-1:0]);
            ALU_SRA: result = shift_big ? {WIDTH{a[WIDTH-1]}} : sra_val;
            ALU_NOT: result = ~a;
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_GTU: result = {{(WIDTH-1){1'b0}}, (a > b)};
            default: result = a + b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU; one
// transaction in flight, IDLE -> EXEC -> RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int RR_INIT = 0,
    parameter int WIDTH   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    arb_state_e state, state_next;

    logic              ptr;
    logic [N_REQ-1:0]  grant;
    logic              grant_id;
    logic              accept;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CTRL_W-1:0] op_ctrl;
    logic              op_id;

    logic [WIDTH-1:0]  alu_y;
    logic              alu_zero;

    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_zero_q;
    logic              rsp_id_q;

    // Contention is resolved by the pointer, which only moves on acceptance.
    always_comb begin
        grant = '0;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    assign grant_id      = grant[1];
    assign bus.req_ready = ((state == ST_IDLE) && rst_n) ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = ST_EXEC;
            ST_EXEC:                    state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'(RR_INIT);
            op_a       <= '0;
            op_b       <= '0;
            op_ctrl    <= '0;
            op_id      <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_a    <= grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                op_b    <= grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                op_ctrl <= grant_id ? bus.req_ctrl[2*CTRL_W-1:CTRL_W]
                                    : bus.req_ctrl[CTRL_W-1:0];
                op_id   <= grant_id;
                ptr     <= ~grant_id;
            end
            if (state == ST_EXEC) begin
                rsp_data_q <= alu_y;
                rsp_zero_q <= alu_zero;
                rsp_id_q   <= op_id;
            end
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .ctrl   (op_ctrl),
        .result (alu_y),
        .zero   (alu_zero)
    );

    // RESP is entered only from the EXEC load edge, so the state itself is the
    // registered response-valid flag.
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_INIT, 0, requester holding priority after reset (0 or 1).
REQ-002 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-007 Port: req_ready  output  2  per-requester accept; one-hot or zero.
REQ-008 Port: req_a  input  64  operand A; requester i on bits [32i+31:32i].
REQ-009 Port: req_b  input  64  operand B; same packing as req_a.
REQ-010 Port: req_ctrl  input  8  4-bit ALU control; requester i on bits [4i+3:4i].
REQ-011 Port: rsp_valid  output  1  result available.
REQ-012 Port: rsp_ready  input  1  consumer accepts result.
REQ-013 Port: rsp_data  output  32  registered ALU result.
REQ-014 Port: rsp_zero  output  1  high when rsp_data == 0.
REQ-015 Port: rsp_id  output  1  index of the requester that owns rsp_data.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; one transaction in flight at most.
REQ-018 IDLE: req_ready = grant one-hot; zero in EXEC and RESP.
REQ-019 Grant: only one requester valid -> that requester; both valid -> requester named by priority pointer; none -> no grant.
REQ-020 Handshake req_valid[i] & req_ready[i] at edge N: capture a/b/ctrl/id of i into operand registers, enter EXEC, set pointer to ~i.
REQ-021 Pointer changes only on an accepted request; grant is therefore stable across IDLE cycles while inputs are held.
REQ-022 Requester contract: once req_valid[i] rises, a/b/ctrl are held stable until accepted; req_valid never depends on req_ready.
REQ-023 EXEC, one cycle: ALU evaluates the captured operands; at edge N+1, rsp_data, rsp_zero and rsp_id are loaded, rsp_valid is set, and the FSM enters RESP.
REQ-024 Latency: rsp_valid is first high in the cycle after edge N+1, i.e. two edges after acceptance.
REQ-025 ALU control codes: 0 add, 1 sub, 2 shl, 3 shr logical, 4 shr arithmetic, 5 NOT A, 6 OR, 7 AND, 8 unsigned A>B (result 1/0), 9-15 add.
REQ-026 Arithmetic: modulo 2^32, with no carry or overflow output; shift amount is the full B value, and B >= 32 yields 0 (sign fill for code 4).
REQ-027 RESP: rsp_data, rsp_zero, rsp_id and rsp_valid are held stable until rsp_valid & rsp_ready.
REQ-028 On the response handshake edge: clear rsp_valid and enter IDLE; a new request can be accepted in the next cycle (peak throughput 1 op per 3 cycles).
REQ-029 A request arriving during EXEC or RESP waits; it is neither dropped nor reordered.

Reset
REQ-030 rst_n low asynchronously forces: state IDLE, pointer RR_INIT, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_id 0, busy 0, req_ready 0.
REQ-031 Reset during EXEC or RESP aborts the transaction; no response is ever issued for it.
REQ-032 After rst_n rises, the first acceptance occurs no earlier than the first rising clk edge.

Structure
REQ-033 Shared package alu_pkg holds the 4-bit ALU control code constants and the arbiter state encoding.
REQ-034 The existing alu block is instantiated exactly once as the sole sub-module, fed from the operand registers; its zero output drives the rsp_zero register.

Verification
REQ-035 Reset: hold rst_n low mid-RESP -> all outputs 0 immediately; no rsp_valid after release.
REQ-036 Single request: req0 a=5, b=7, ctrl=0 accepted at edge N -> rsp_valid at N+2, rsp_data 12, rsp_zero 0, rsp_id 0.
REQ-037 Round-robin: both valid continuously with RR_INIT=0 -> ids 0,1,0,1; req1 a=3, b=3, ctrl=1 -> rsp_data 0, rsp_zero 1.
REQ-038 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready 00; rsp_ready high -> IDLE next cycle.
REQ-039 Operations: a=0x80000000, b=4, ctrl=4 -> 0xF8000000; a=1, b=0xFFFFFFFF, ctrl=8 -> 0; ctrl=0xF, a=2, b=3 -> 5.
